// File: rtl/aes_prng_feeder.sv
// rtl/aes_prng_feeder.sv - xorshift128 randomness source with warm-up and output FIFO; optional repetition test under `AES_RNG_HEALTH_EN
module aes_prng_feeder #(
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WARMUP     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             seed_valid_i,
  input  logic [127:0]     seed_i,
  output logic             seed_ready_o,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic [OUT_W-1:0] rand_o,
  output logic             busy_o,
  output logic             health_fail_o
);

  localparam int N  = OUT_W / 32;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [127:0] ZERO_SEED = 128'h075BCD15_159A55E5_1F123BB5_05491333;

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t           state_q;
  logic             rdy_q;
  logic [127:0]     st_q;
  logic [SW-1:0]    step_cnt_q;
  logic [WW-1:0]    warm_cnt_q;
  logic [OUT_W-1:0] part_q;
  logic [OUT_W-1:0] stage_q;
  logic             stage_vld_q;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             health_q;

  logic             seed_acc;
  logic [31:0]      t;
  logic [31:0]      w_new;
  logic [127:0]     st_next;
  logic [CW-1:0]    occ;
  logic             run_step;
  logic             step_en;
  logic             last_step;
  logic [OUT_W-1:0] word_next;
  logic             push;
  logic             pop;
  logic             rep_fail;

  // Next PRNG state and packing of the new 32-bit output into the partial word
  always_comb begin
    seed_acc  = seed_valid_i & rdy_q;
    t         = st_q[127:96] ^ (st_q[127:96] << 11);
    w_new     = st_q[31:0] ^ (st_q[31:0] >> 19) ^ t ^ (t >> 8);
    st_next   = {st_q[95:0], w_new};
    // Words in the FIFO plus the one waiting in the stage register bound stepping,
    // so a completed word always has a free slot when it is pushed.
    occ       = count_q + CW'(stage_vld_q);
    run_step  = (state_q == RUN) && (occ < CW'(FIFO_DEPTH));
    step_en   = (state_q == WARM) || run_step;
    last_step = (step_cnt_q == SW'(N - 1));
    word_next = part_q;
    word_next[{step_cnt_q, 5'd0} +: 32] = w_new;
    push      = stage_vld_q;
    pop       = rand_valid_o && rand_ready_i && (state_q != IDLE);
  end

`ifdef AES_RNG_HEALTH_EN
  logic [31:0] hist_q;
  logic        hist_vld_q;

  // Repetition test: a RUN step output equal to the previous one is a failure
  always_comb rep_fail = run_step && hist_vld_q && (w_new == hist_q);

  // History of the last RUN step output, restarted on every seed load
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else if (seed_acc) begin
      hist_vld_q <= 1'b0;
    end else if (run_step) begin
      hist_q     <= w_new;
      hist_vld_q <= 1'b1;
    end
  end

  assign health_fail_o = health_q;
`else
  assign rep_fail      = 1'b0;
  assign health_fail_o = 1'b0;
`endif

  assign seed_ready_o = rdy_q;
  assign rand_valid_o = (count_q != '0);
  assign rand_o       = rand_valid_o ? mem[rd_ptr_q] : '0;
  assign busy_o       = (state_q == WARM);

  // FIFO storage; contents are only visible through rand_o when count is nonzero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= stage_q;
  end

  // Control FSM, PRNG state, word assembly and FIFO pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      st_q        <= '0;
      step_cnt_q  <= '0;
      warm_cnt_q  <= '0;
      part_q      <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      health_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (seed_acc) begin
        st_q        <= (seed_i == '0) ? ZERO_SEED : seed_i;
        state_q     <= (WARMUP == 0) ? RUN : WARM;
        step_cnt_q  <= '0;
        warm_cnt_q  <= '0;
        part_q      <= '0;
        stage_vld_q <= 1'b0;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        count_q     <= '0;
        health_q    <= 1'b0;
      end else if (rep_fail) begin
        health_q    <= 1'b1;
        state_q     <= IDLE;
        step_cnt_q  <= '0;
        part_q      <= '0;
        stage_vld_q <= 1'b0;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        count_q     <= '0;
      end else begin
        if (step_en) st_q <= st_next;
        if (state_q == WARM) begin
          warm_cnt_q <= warm_cnt_q + 1'b1;
          if (warm_cnt_q == WW'(WARMUP - 1)) begin
            warm_cnt_q <= '0;
            state_q    <= RUN;
          end
        end
        if (push) stage_vld_q <= 1'b0;
        if (run_step) begin
          if (last_step) begin
            stage_q     <= word_next;
            stage_vld_q <= 1'b1;
            part_q      <= '0;
            step_cnt_q  <= '0;
          end else begin
            part_q     <= word_next;
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
